// File: rtl/zbt_pkg.sv
// rtl/zbt_pkg.sv - shared ZBT geometry, point record layout and reader FSM states
package zbt_pkg;

  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;
  localparam int ZBT_RD_LAT = 2;

  localparam int X_LSB   = 20;
  localparam int Y_LSB   = 10;
  localparam int VAL_LSB = 0;
  localparam int FIELD_W = 10;
  localparam int PAD_LSB = 30;

  typedef struct packed {
    logic [5:0]         pad;
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] val;
  } point_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; DEPTH must be a power of two
module sync_fifo #(
  parameter  int DATA_W = 36,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/read_from_zbt.sv
// rtl/read_from_zbt.sv - streams point records out of ZBT SRAM; ZBT_PAD_CHECK_EN drops words with nonzero pad bits
module read_from_zbt
  import zbt_pkg::*;
#(
  parameter int ADDR_W     = ZBT_ADDR_W,
  parameter int DATA_W     = ZBT_DATA_W,
  parameter int RD_LAT     = ZBT_RD_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  count,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  zbt_addr,
  output logic               zbt_we,
  input  logic [DATA_W-1:0]  zbt_read_data,
  output logic [FIELD_W-1:0] pt_x,
  output logic [FIELD_W-1:0] pt_y,
  output logic [FIELD_W-1:0] pt_val,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic               pad_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         state, state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rem;
  logic [RD_LAT-1:0] tok_sr;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW:0]       used;
  logic              tok_exit, push, pop, drop;
  logic              credit_ok, drained;
  logic              issue, load, done_next;
  logic              unused_pad;

  assign tok_exit = tok_sr[RD_LAT-1];
  assign pt_valid = (fifo_count != '0);
  assign pop      = pt_valid && pt_ready;
  assign push     = tok_exit && !drop;
  assign busy     = (state != ST_IDLE);
  assign zbt_we   = 1'b0;

  // Occupancy plus reads in flight may never exceed the FIFO, so returning data always has a slot.
  assign used      = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(drop);
  assign credit_ok = used < (CW+1)'(FIFO_DEPTH);
  assign drained   = (inflight == '0) &&
                     ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

`ifdef ZBT_PAD_CHECK_EN
  assign drop = tok_exit && (|zbt_read_data[DATA_W-1:PAD_LSB]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pad_err <= 1'b0;
    else if (drop) pad_err <= 1'b1;
  end
`else
  assign drop    = 1'b0;
  assign pad_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    load       = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (count != '0) begin
            load       = 1'b1;
            state_next = ST_READ;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rem == ADDR_W'(1)) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr  <= '0;
      rem      <= '0;
      zbt_addr <= '0;
      tok_sr   <= '0;
      inflight <= '0;
      done     <= 1'b0;
    end else begin
      done     <= done_next;
      tok_sr   <= (tok_sr << 1) | RD_LAT'(issue);
      inflight <= inflight + CW'(issue) - CW'(tok_exit);
      if (load) begin
        rd_addr <= base_addr;
        rem     <= count;
      end else if (issue) begin
        zbt_addr <= rd_addr;
        rd_addr  <= rd_addr + ADDR_W'(1);
        rem      <= rem - ADDR_W'(1);
      end
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (zbt_read_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count)
  );

  assign pt_x       = fifo_dout[X_LSB +: FIELD_W];
  assign pt_y       = fifo_dout[Y_LSB +: FIELD_W];
  assign pt_val     = fifo_dout[VAL_LSB +: FIELD_W];
  assign unused_pad = ^fifo_dout[DATA_W-1:PAD_LSB];

endmodule
